// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// master drives start/a/b and collects the result; slave is the subtractor.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor bit per clock, LSB first,
// borrow held in a flop between bits; start/busy/done handshake.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input logic          clk,
   input logic          reset,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   // Bit 0 of the result register would only ever be shifted out, so it is not stored.
   logic [WIDTH-1:1] r_q, r_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             bor_q, bor_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             d_bit;
   logic             bor_nxt;
   logic [WIDTH-1:0] r_shift;

   always_comb begin
      d_bit   = sa_q[0] ^ sb_q[0] ^ bor_q;
      bor_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bor_q);
      r_shift = {d_bit, r_q};

      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      bor_d    = bor_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               sa_d    = bus.a;
               sb_d    = bus.b;
               bor_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            r_d   = r_shift[WIDTH-1:1];
            bor_d = bor_nxt;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               diff_d   = r_shift;
               borrow_d = bor_nxt;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = StDone;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         sa_q     <= '0;
         sb_q     <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         bor_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         bor_q    <= bor_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level model built from operation timing and
// plain unsigned arithmetic, checked every cycle, plus directed literal checks.
module tb_serial_subtractor;
   localparam int unsigned W = 8;

   logic clk;
   logic reset;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: an accepted operation keeps busy for W cycles, then a single done cycle
   // publishes (a - b) mod 2^W and a < b.
   int         m_rem = 0;
   logic       m_done = 1'b0;
   logic [W-1:0] m_diff = '0, m_pend = '0;
   logic       m_bor = 1'b0, m_pbor = 1'b0;
   bit         model_ok = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_rem = 0; m_done = 1'b0; m_diff = '0; m_bor = 1'b0;
         model_ok = 1'b1;
      end else if (bus.start && m_rem == 0) begin
         m_rem  = W;
         m_pend = bus.a - bus.b;
         m_pbor = (bus.a < bus.b);
         m_done = 1'b0;
      end else if (m_rem > 0) begin
         m_rem--;
         m_done = (m_rem == 0);
         if (m_rem == 0) begin
            m_diff = m_pend;
            m_bor  = m_pbor;
         end
      end else begin
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("busy",       32'(bus.busy),       32'(m_rem > 0));
         check("done",       32'(bus.done),       32'(m_done));
         check("diff",       32'(bus.diff),       32'(m_diff));
         check("borrow_out", 32'(bus.borrow_out), 32'(m_bor));
      end
   end

   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int bcnt);
      @(negedge clk);
      bus.start = 1'b1; bus.a = av; bus.b = bv;
      @(negedge clk);
      bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
      lat = 1;
      bcnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < 64) begin
         @(negedge clk);
         lat++;
         if (bus.busy) bcnt++;
      end
      if (!bus.done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic op_expect(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] ed, input logic eb);
      int lat, bcnt;
      do_op(av, bv, lat, bcnt);
      check({name, "_diff"},   32'(bus.diff),       32'(ed));
      check({name, "_borrow"}, 32'(bus.borrow_out), 32'(eb));
   endtask

   initial begin
      int lat, bcnt, dones;
      reset = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_bor",  32'(bus.borrow_out), 32'd0);
      reset = 1'b0;

      do_op(8'd5, 8'd3, lat, bcnt);
      check("t1_latency", 32'(lat), 32'd9);
      check("t1_busy_cycles", 32'(bcnt), 32'd8);
      check("t1_diff", 32'(bus.diff), 32'h02);
      check("t1_borrow", 32'(bus.borrow_out), 32'd0);

      op_expect("t2a", 8'd3, 8'd5, 8'hFE, 1'b1);
      op_expect("t2b", 8'h00, 8'hFF, 8'h01, 1'b1);
      op_expect("t3a", 8'hA5, 8'hA5, 8'h00, 1'b0);
      op_expect("t3b", 8'hFF, 8'h00, 8'hFF, 1'b0);

      // Start pulsed mid-run must be ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'd40; bus.b = 8'd18;
      @(negedge clk);
      bus.start = 1'b0; bus.a = 8'd1; bus.b = 8'd200;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.start = (i == 3);
         if (bus.done) dones++;
      end
      check("t4_done_count", 32'(dones), 32'd1);
      check("t4_diff", 32'(bus.diff), 32'd22);
      check("t4_borrow", 32'(bus.borrow_out), 32'd0);

      // Back-to-back: start held through the done cycle.
      do_op(8'h20, 8'h07, lat, bcnt);
      bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
      @(negedge clk);
      bus.start = 1'b0; bus.a = 8'hEE; bus.b = 8'hEF;
      check("t5_busy_again", 32'(bus.busy), 32'd1);
      check("t5_first_held", 32'(bus.diff), 32'h19);
      lat = 1;
      while (!bus.done && lat < 64) begin
         @(negedge clk);
         lat++;
         if (!bus.done && lat <= 8) check("t5_hold", 32'(bus.diff), 32'h19);
      end
      check("t5_latency", 32'(lat), 32'd9);
      check("t5_diff", 32'(bus.diff), 32'h0F);
      check("t5_borrow", 32'(bus.borrow_out), 32'd0);

      // Reset in the middle of a run aborts with no done pulse.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'd7; bus.b = 8'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_busy", 32'(bus.busy), 32'd0);
      check("t6_diff", 32'(bus.diff), 32'd0);
      check("t6_borrow", 32'(bus.borrow_out), 32'd0);
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("t6_no_done", 32'(dones), 32'd0);
      op_expect("t6_fresh", 8'd9, 8'd4, 8'd5, 1'b0);

      // Random traffic, including occasional resets and start overlap.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         reset     = ($urandom_range(0, 249) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.a     = W'($urandom);
         bus.b     = W'($urandom);
      end
      @(negedge clk);
      reset = 1'b0; bus.start = 1'b0;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b. It is the inverse-operation counterpart to the team's full-adder sum primitive.
- Each clock evaluates one full-subtractor bit, LSB first, and holds the borrow in a flip-flop between bits.
- A start/busy/done handshake lets a testbench or controller launch an operation and collect the result.
- Sits beside the combinational adder cells as the sequential teaching and reference block for ripple arithmetic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- start  input  1  request to begin an operation; sampled on rising clk.
- a  input  WIDTH  minuend; captured only on the edge that accepts start.
- b  input  WIDTH  subtrahend; captured only on the edge that accepts start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse marking diff/borrow_out valid.
- diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b as unsigned.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, bit counter=0, internal borrow=0, operand shift registers=0.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 at an edge captures a into shift register SA and b into SB.
  - The same edge clears internal borrow and counter and moves to RUN.
  - busy goes high in the following cycle.
- RUN, each edge:
  - Compute d = SA[0] ^ SB[0] ^ bor.
  - Compute bor_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & bor).
  - Shift SA and SB right by one. Shift d into the MSB of the internal result register R.
  - Increment the counter.
  - On the edge where counter == WIDTH-1 (the WIDTH-th bit): load diff from the final R, load borrow_out from bor_next, and move to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge returns to IDLE, unless start=1 (see below).
- Latency: start accepted at edge E0 -> done high in the cycle after edge E(WIDTH). busy is high for exactly WIDTH cycles.
- diff and borrow_out change only on the completion edge. They hold their value through IDLE and any later RUN until the next completion.
- start is ignored while in RUN. a and b may change freely after acceptance without affecting the result.
- start=1 in the DONE cycle is accepted: operands are captured and the block goes directly to RUN, giving back-to-back operations with no IDLE gap.
- reset asserted mid-operation (any state) aborts. The next edge returns all registers to reset values, including diff=0, and no done pulse is produced.
- reset and start both high: reset wins.
- Arithmetic: unsigned modulo 2^WIDTH. There is no overflow flag; borrow_out is the only out-of-range indicator.

Test Plan:
1. WIDTH=8, a=8'd5, b=8'd3, pulse start -> busy high 8 cycles, done pulse in 9th cycle after the accept edge, diff=8'h02, borrow_out=0.
2. a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1. Also a=8'h00, b=8'hFF -> diff=8'h01, borrow_out=1.
3. a=b=8'hA5 -> diff=8'h00, borrow_out=0. a=8'hFF, b=8'h00 -> diff=8'hFF, borrow_out=0.
4. Pulse start again mid-RUN, with different a/b changed after acceptance -> ignored; result of the first operation unchanged; exactly one done pulse.
5. Hold start=1 through the DONE cycle with new operands a=8'h10, b=8'h01 -> busy re-asserts the next cycle; second done yields diff=8'h0F. The first result held until then.
6. Assert reset for one cycle at RUN bit 4 -> busy=0, done never pulses, diff=0, borrow_out=0. A fresh start then completes normally.
